ctrl_stage_pipe: RTL and testbench
==================================

// Module: ctrl_stage_pipe
// PURPOSE
//  Carries decoded control bundle from ID through ID/EX, EX/MEM, MEM/WB control registers.
//  Sits directly downstream of the main control decoder; consumes its WB/M/EX fields plus rs/rt.
//  Inserts bubbles on load-use hazard, branch flush and illegal opcode; freezes on back-pressure.
//  Counts hazard bubbles for performance debug.
// PARAMETERS
//  ALUOP_W   3       width of ALU operation code
//  RADDR_W   5       register address width
//  NOP_ALUOP 3'b000  ALU op driven in a bubble
//  CNT_W     8       hazard bubble counter width (saturating)
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  id_valid     in   1        ID holds a real instruction
//  id_illegal   in   1        decoder hit default case (fields may be X)
//  id_reg_dst   in   1        ID control fields from decoder...
//  id_branch    in   1
//  id_mem_read  in   1
//  id_mem_to_reg in  1
//  id_alu_op    in   ALUOP_W
//  id_mem_write in   1
//  id_alu_src   in   1
//  id_reg_write in   1
//  id_rs        in   RADDR_W  source register 1 of ID instruction
//  id_rt        in   RADDR_W  source/dest register 2 of ID instruction
//  id_uses_rt   in   1        ID instruction reads rt as a source
//  hold_i       in   1        global freeze (memory wait)
//  flush_i      in   1        branch taken, resolved in MEM
//  hazard_o     out  1        load-use stall request to PC/IF-ID (combinational)
//  illegal_o    out  1        1-cycle pulse: illegal instruction squashed
//  ex_valid, ex_reg_dst, ex_alu_src  out 1; ex_alu_op out ALUOP_W; ex_rt out RADDR_W
//  mem_valid, mem_branch, mem_mem_read, mem_mem_write  out 1
//  wb_valid, wb_mem_to_reg, wb_reg_write  out 1
//  hz_cnt_o     out  CNT_W    saturating count of hazard bubbles
// BEHAVIOUR
//  Reset: all outputs, valids, fields 0; ex_alu_op=NOP_ALUOP; hz_cnt_o=0. Async: clears mid-cycle.
//  Bubble = valid 0, all control fields 0, alu_op NOP_ALUOP, ex_rt 0. X never enters a register.
//  Latency: ID fields visible at EX outputs +1 clk, MEM +2, WB +3 (no hazard/hold).
//  Per-edge priority: hold_i > flush_i > hazard > normal advance.
//  hold_i=1: all three stages keep contents; counter, illegal_o unchanged/0; hazard_o still computed.
//  flush_i=1 (no hold): WB<=MEM (branch retires); MEM<=bubble; EX<=bubble; ID entry dropped.
//   flush_i during hold is ignored; source keeps flush_i asserted until hold_i drops.
//  hazard_o = ex_valid & ex_mem_read_int & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)) & id_valid.
//   On hazard edge (no hold/flush): WB<=MEM, MEM<=EX, EX<=bubble; hz_cnt_o+1, saturates at all-ones.
//   Upstream holds IF/ID while hazard_o=1; next cycle ex is bubble so hazard_o drops.
//  Normal advance: WB<=MEM, MEM<=EX, EX<=ID if id_valid & ~id_illegal, else bubble.
//  id_valid & id_illegal on a normal advance: EX<=bubble, illegal_o=1 for exactly that next cycle.
//  EX stage internally keeps mem_read/mem_write/branch/mem_to_reg/reg_write to forward to MEM/WB.
//  Outputs are registered except hazard_o.
// TESTING
//  R-type (reg_dst=1,alu_op=010,reg_write=1) each cycle -> ex @+1, wb_reg_write=1 @+3, valids 1.
//  lw rt=5 then add rs=5 -> hazard_o=1 one cycle, EX bubble, add in EX 2 clks after lw, hz_cnt_o=1.
//  lw rt=0 then add rs=0 -> hazard_o=0, no bubble; 300 forced hazards -> hz_cnt_o holds 255.
//  beq in MEM + flush_i=1 -> WB gets beq, mem_valid=0, ex_valid=0 next cycle; hold_i+flush_i -> no change.
//  id_illegal=1 with X fields -> ex_valid=0, all ex fields 0 (no X), illegal_o=1 one cycle.
//  rst_n low mid-stream with valid stages -> all outputs 0 immediately, before next clk edge.

Source files
------------

// File: rtl/ctrl_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_stage_pipe
// Brief    : ID/EX, EX/MEM, MEM/WB control-bundle pipeline with load-use
//            bubble insertion, branch flush, illegal-op squash, freeze on hold
//            and a saturating hazard-bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_stage_pipe #(
    parameter int                 ALUOP_W   = 3,
    parameter int                 RADDR_W   = 5,
    parameter logic [ALUOP_W-1:0] NOP_ALUOP = 3'b000,
    parameter int                 CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic               id_illegal,
    input  logic               id_reg_dst,
    input  logic               id_branch,
    input  logic               id_mem_read,
    input  logic               id_mem_to_reg,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               id_mem_write,
    input  logic               id_alu_src,
    input  logic               id_reg_write,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic               id_uses_rt,
    input  logic               hold_i,
    input  logic               flush_i,
    output logic               hazard_o,
    output logic               illegal_o,
    output logic               ex_valid,
    output logic               ex_reg_dst,
    output logic               ex_alu_src,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [RADDR_W-1:0] ex_rt,
    output logic               mem_valid,
    output logic               mem_branch,
    output logic               mem_mem_read,
    output logic               mem_mem_write,
    output logic               wb_valid,
    output logic               wb_mem_to_reg,
    output logic               wb_reg_write,
    output logic [CNT_W-1:0]   hz_cnt_o
);

    typedef struct packed {
        logic               valid;
        logic               reg_dst;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic [RADDR_W-1:0] rt;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               mem_to_reg;
        logic               reg_write;
    } ex_t;

    typedef struct packed {
        logic valid;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } mem_t;

    typedef struct packed {
        logic valid;
        logic mem_to_reg;
        logic reg_write;
    } wb_t;

    ex_t              r_ex;
    mem_t             r_mem;
    wb_t              r_wb;
    logic             r_illegal;
    logic [CNT_W-1:0] r_hz_cnt;

    ex_t  w_ex_bubble;
    ex_t  w_ex_from_id;
    mem_t w_mem_from_ex;
    wb_t  w_wb_from_mem;
    logic w_hazard;
    logic w_id_accept;

    always_comb begin
        w_ex_bubble        = '0;
        w_ex_bubble.alu_op = NOP_ALUOP;

        w_ex_from_id            = '0;
        w_ex_from_id.valid      = 1'b1;
        w_ex_from_id.reg_dst    = id_reg_dst;
        w_ex_from_id.alu_src    = id_alu_src;
        w_ex_from_id.alu_op     = id_alu_op;
        w_ex_from_id.rt         = id_rt;
        w_ex_from_id.mem_read   = id_mem_read;
        w_ex_from_id.mem_write  = id_mem_write;
        w_ex_from_id.branch     = id_branch;
        w_ex_from_id.mem_to_reg = id_mem_to_reg;
        w_ex_from_id.reg_write  = id_reg_write;

        w_mem_from_ex.valid      = r_ex.valid;
        w_mem_from_ex.branch     = r_ex.branch;
        w_mem_from_ex.mem_read   = r_ex.mem_read;
        w_mem_from_ex.mem_write  = r_ex.mem_write;
        w_mem_from_ex.mem_to_reg = r_ex.mem_to_reg;
        w_mem_from_ex.reg_write  = r_ex.reg_write;

        w_wb_from_mem.valid      = r_mem.valid;
        w_wb_from_mem.mem_to_reg = r_mem.mem_to_reg;
        w_wb_from_mem.reg_write  = r_mem.reg_write;
    end

    // Load in EX whose destination feeds the ID instruction; r0 never hazards.
    assign w_hazard = r_ex.valid & r_ex.mem_read & (r_ex.rt != '0) &
                      ((r_ex.rt == id_rs) | (id_uses_rt & (r_ex.rt == id_rt))) &
                      id_valid;

    assign w_id_accept = id_valid & ~id_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex        <= '0;
            r_ex.alu_op <= NOP_ALUOP;
            r_mem       <= '0;
            r_wb        <= '0;
            r_illegal   <= 1'b0;
            r_hz_cnt    <= '0;
        end else begin
            r_illegal <= 1'b0;
            if (!hold_i) begin
                r_wb <= w_wb_from_mem;
                if (flush_i) begin
                    r_mem <= '0;
                    r_ex  <= w_ex_bubble;
                end else begin
                    r_mem <= w_mem_from_ex;
                    if (w_hazard) begin
                        r_ex <= w_ex_bubble;
                        if (!(&r_hz_cnt)) begin
                            r_hz_cnt <= r_hz_cnt + 1'b1;
                        end
                    end else if (w_id_accept) begin
                        r_ex <= w_ex_from_id;
                    end else begin
                        r_ex      <= w_ex_bubble;
                        r_illegal <= id_valid & id_illegal;
                    end
                end
            end
        end
    end

    assign hazard_o      = w_hazard;
    assign illegal_o     = r_illegal;
    assign ex_valid      = r_ex.valid;
    assign ex_reg_dst    = r_ex.reg_dst;
    assign ex_alu_src    = r_ex.alu_src;
    assign ex_alu_op     = r_ex.alu_op;
    assign ex_rt         = r_ex.rt;
    assign mem_valid     = r_mem.valid;
    assign mem_branch    = r_mem.branch;
    assign mem_mem_read  = r_mem.mem_read;
    assign mem_mem_write = r_mem.mem_write;
    assign wb_valid      = r_wb.valid;
    assign wb_mem_to_reg = r_wb.mem_to_reg;
    assign wb_reg_write  = r_wb.reg_write;
    assign hz_cnt_o      = r_hz_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_stage_pipe
// Brief    : Table-driven directed bench for ctrl_stage_pipe plus hand-written
//            flush, illegal, saturation and async-reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_stage_pipe;

    typedef struct packed {
        logic       valid, illegal, reg_dst, branch, mem_read, mem_to_reg;
        logic [2:0] alu_op;
        logic       mem_write, alu_src, reg_write;
        logic [4:0] rs, rt;
        logic       uses_rt, hold, flush;
    } in_t;

    typedef struct packed {
        logic       hazard, ex_valid;
        logic [2:0] ex_alu_op;
        logic [4:0] ex_rt;
        logic       mem_valid, mem_read, wb_valid, wb_reg_write, illegal;
        logic [7:0] cnt;
    } exp_t;

    typedef struct {
        in_t  in;
        exp_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_illegal, id_reg_dst, id_branch, id_mem_read, id_mem_to_reg;
    logic [2:0] id_alu_op;
    logic       id_mem_write, id_alu_src, id_reg_write;
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rt, hold_i, flush_i;
    logic       hazard_o, illegal_o, ex_valid, ex_reg_dst, ex_alu_src;
    logic [2:0] ex_alu_op;
    logic [4:0] ex_rt;
    logic       mem_valid, mem_branch, mem_mem_read, mem_mem_write;
    logic       wb_valid, wb_mem_to_reg, wb_reg_write;
    logic [7:0] hz_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    ctrl_stage_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_illegal(id_illegal), .id_reg_dst(id_reg_dst),
        .id_branch(id_branch), .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg),
        .id_alu_op(id_alu_op), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .hold_i(hold_i), .flush_i(flush_i), .hazard_o(hazard_o), .illegal_o(illegal_o),
        .ex_valid(ex_valid), .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
        .ex_alu_op(ex_alu_op), .ex_rt(ex_rt), .mem_valid(mem_valid), .mem_branch(mem_branch),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .wb_valid(wb_valid),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .hz_cnt_o(hz_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic in_t f_idle();
        in_t v = '0;
        return v;
    endfunction

    function automatic in_t f_r(input logic [4:0] rs, input logic [4:0] rt, input logic uses);
        in_t v = '0;
        v.valid = 1'b1; v.reg_dst = 1'b1; v.alu_op = 3'b010; v.reg_write = 1'b1;
        v.rs = rs; v.rt = rt; v.uses_rt = uses;
        return v;
    endfunction

    function automatic in_t f_lw(input logic [4:0] rs, input logic [4:0] rt);
        in_t v = '0;
        v.valid = 1'b1; v.mem_read = 1'b1; v.mem_to_reg = 1'b1; v.alu_src = 1'b1;
        v.reg_write = 1'b1; v.rs = rs; v.rt = rt;
        return v;
    endfunction

    function automatic in_t f_ill();
        in_t v = 'x;
        v.valid = 1'b1; v.illegal = 1'b1; v.hold = 1'b0; v.flush = 1'b0;
        return v;
    endfunction

    function automatic exp_t f_e(input logic h, input logic ev, input logic [2:0] op,
                                 input logic [4:0] rt, input logic mv, input logic mr,
                                 input logic wv, input logic wr, input logic il,
                                 input logic [7:0] cnt);
        exp_t e;
        e.hazard = h; e.ex_valid = ev; e.ex_alu_op = op; e.ex_rt = rt;
        e.mem_valid = mv; e.mem_read = mr; e.wb_valid = wv; e.wb_reg_write = wr;
        e.illegal = il; e.cnt = cnt;
        return e;
    endfunction

    task automatic drive(input in_t v);
        id_valid = v.valid; id_illegal = v.illegal; id_reg_dst = v.reg_dst;
        id_branch = v.branch; id_mem_read = v.mem_read; id_mem_to_reg = v.mem_to_reg;
        id_alu_op = v.alu_op; id_mem_write = v.mem_write; id_alu_src = v.alu_src;
        id_reg_write = v.reg_write; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt;
        hold_i = v.hold; flush_i = v.flush;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(f_idle());
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [31:0] all_outs();
        return {7'd0, hazard_o, illegal_o, ex_valid, ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt,
                mem_valid, mem_branch, mem_mem_read, mem_mem_write,
                wb_valid, wb_mem_to_reg, wb_reg_write, hz_cnt_o};
    endfunction

    function automatic logic [31:0] obs();
        exp_t o;
        o.hazard = 1'b0; o.ex_valid = ex_valid; o.ex_alu_op = ex_alu_op; o.ex_rt = ex_rt;
        o.mem_valid = mem_valid; o.mem_read = mem_mem_read; o.wb_valid = wb_valid;
        o.wb_reg_write = wb_reg_write; o.illegal = illegal_o; o.cnt = hz_cnt_o;
        return 32'(o);
    endfunction

    vec_t vecs[20];
    in_t  tmp;
    exp_t e;

    initial begin
        vecs[0]  = '{f_r(1, 2, 1),  f_e(0, 1, 3'b010, 2, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{f_r(3, 4, 1),  f_e(0, 1, 3'b010, 4, 1, 0, 0, 0, 0, 0)};
        vecs[2]  = '{f_lw(6, 5),    f_e(0, 1, 3'b000, 5, 1, 0, 1, 1, 0, 0)};
        vecs[3]  = '{f_r(5, 7, 1),  f_e(1, 0, 3'b000, 0, 1, 1, 1, 1, 0, 1)};
        vecs[4]  = '{f_r(5, 7, 1),  f_e(0, 1, 3'b010, 7, 0, 0, 1, 1, 0, 1)};
        vecs[5]  = '{f_lw(0, 0),    f_e(0, 1, 3'b000, 0, 1, 0, 0, 0, 0, 1)};
        vecs[6]  = '{f_r(0, 0, 1),  f_e(0, 1, 3'b010, 0, 1, 1, 1, 1, 0, 1)};
        vecs[7]  = '{f_ill(),       f_e(0, 0, 3'b000, 0, 1, 0, 1, 1, 1, 1)};
        vecs[8]  = '{f_idle(),      f_e(0, 0, 3'b000, 0, 0, 0, 1, 1, 0, 1)};
        vecs[9]  = '{f_idle(),      f_e(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1)};
        vecs[10] = '{f_lw(0, 9),    f_e(0, 1, 3'b000, 9, 0, 0, 0, 0, 0, 1)};
        vecs[11] = '{f_r(1, 9, 1),  f_e(1, 0, 3'b000, 0, 1, 1, 0, 0, 0, 2)};
        vecs[12] = '{f_lw(0, 9),    f_e(0, 1, 3'b000, 9, 0, 0, 1, 1, 0, 2)};
        vecs[13] = '{f_r(1, 9, 0),  f_e(0, 1, 3'b010, 9, 1, 1, 0, 0, 0, 2)};
        tmp = f_r(9, 3, 1); tmp.hold = 1'b1;
        vecs[14] = '{tmp,           f_e(0, 1, 3'b010, 9, 1, 1, 0, 0, 0, 2)};
        tmp.flush = 1'b1;
        vecs[15] = '{tmp,           f_e(0, 1, 3'b010, 9, 1, 1, 0, 0, 0, 2)};
        tmp.hold = 1'b0;
        vecs[16] = '{tmp,           f_e(0, 0, 3'b000, 0, 0, 0, 1, 1, 0, 2)};
        vecs[17] = '{f_lw(0, 4),    f_e(0, 1, 3'b000, 4, 0, 0, 0, 0, 0, 2)};
        tmp = f_r(4, 1, 1); tmp.hold = 1'b1;
        vecs[18] = '{tmp,           f_e(1, 1, 3'b000, 4, 0, 0, 0, 0, 0, 2)};
        vecs[19] = '{f_r(4, 1, 1),  f_e(1, 0, 3'b000, 0, 1, 1, 0, 0, 0, 3)};

        do_reset();
        check("reset_state", all_outs(), 32'd0);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].in);
            #1;
            check($sformatf("vec%0d_hazard", i), {31'd0, hazard_o}, {31'd0, vecs[i].exp.hazard});
            tick();
            e = vecs[i].exp;
            e.hazard = 1'b0;
            check($sformatf("vec%0d_outs", i), obs(), 32'(e));
        end

        // Illegal opcode with X fields: bubble with clean zero fields, one-cycle pulse.
        do_reset();
        drive(f_ill());
        tick();
        check("illegal_ex_bundle",
              {20'd0, ex_valid, ex_reg_dst, ex_alu_src, ex_alu_op, ex_rt, illegal_o},
              {20'd0, 11'd0, 1'b1});
        drive(f_idle());
        tick();
        check("illegal_pulse_end", {31'd0, illegal_o}, 32'd0);

        // Branch in MEM: hold+flush freezes, flush alone retires branch and clears MEM/EX.
        tmp = '0; tmp.valid = 1'b1; tmp.branch = 1'b1; tmp.alu_op = 3'b001;
        drive(tmp);
        tick();
        drive(f_r(1, 2, 1));
        tick();
        check("beq_in_mem", {29'd0, mem_valid, mem_branch, ex_valid}, {29'd0, 3'b111});
        tmp = f_r(3, 4, 1); tmp.hold = 1'b1; tmp.flush = 1'b1;
        drive(tmp);
        tick();
        check("hold_flush_frozen", {28'd0, mem_valid, mem_branch, ex_valid, wb_valid},
              {28'd0, 4'b1110});
        tmp.hold = 1'b0;
        drive(tmp);
        tick();
        check("flush_result", {27'd0, wb_valid, wb_reg_write, wb_mem_to_reg, mem_valid, ex_valid},
              {27'd0, 5'b10000});
        drive(f_idle());
        tick();
        check("flush_drops_id", {30'd0, ex_valid, mem_valid}, 32'd0);

        // Counter saturation across 300 forced hazards.
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            drive(f_lw(0, 5));
            tick();
            drive(f_r(5, 6, 1));
            tick();
            if (k == 254) check("cnt_254", {24'd0, hz_cnt_o}, 32'd254);
            if (k == 255) check("cnt_255", {24'd0, hz_cnt_o}, 32'd255);
        end
        check("cnt_saturated", {24'd0, hz_cnt_o}, 32'd255);

        // Async reset mid-cycle with a full pipeline.
        drive(f_r(1, 2, 1));
        repeat (3) tick();
        check("pre_async_full", {29'd0, ex_valid, mem_valid, wb_valid}, {29'd0, 3'b111});
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_clear", all_outs(), 32'd0);
        drive(f_idle());
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
